// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
//
// Purpose:
//   Register file with two write ports and a busy scoreboard for loads. It
//   sits between decode and writeback. Decode reads two operands (A and B)
//   and a branch-offset register. Writeback drives an ALU port (port 0) and a
//   load-return port (port 1). The scoreboard holds one busy bit per
//   register, for loads that have issued but not yet returned. It drives
//   Stall to freeze the front end when a RAW or WAW hazard hits one of
//   those registers.
//
// Parameters:
//   W        data width in bits
//   D        address width; the file holds 2**D registers
//   BYPASS   1: write data this cycle is forwarded to the read ports
//            0: reads see only the stored value
//   ZERO_R0  1: R0 always reads 0, ignores writes and is never busy
//
// Ports:
//   Clk        clock; all state updates on the rising edge
//   Reset      synchronous, active-high; clears registers and busy bits
//   RaddrA     read pointer A
//   RaddrB     read pointer B
//   WriteEn    port 0 (ALU) write enable
//   Waddr      port 0 write pointer; also selects DataOutBr
//   DataIn     port 0 write data
//   LdWriteEn  port 1 (load return) write enable
//   LdWaddr    port 1 write pointer
//   LdDataIn   port 1 write data
//   SetBusy    a load has issued; mark BusyAddr as outstanding
//   BusyAddr   destination register of the issued load
//   DataOutA   value of register RaddrA
//   DataOutB   value of register RaddrB
//   DataOutBr  value of register Waddr (branch offset)
//   BusyA      busy bit of RaddrA
//   BusyB      busy bit of RaddrB
//   Stall      hazard against an outstanding load; freezes the front end
// ---------------------------------------------------------------------------
module reg_file_sb #(
    parameter int W       = 8,
    parameter int D       = 2,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [D-1:0] RaddrA,
    input  logic [D-1:0] RaddrB,
    input  logic         WriteEn,
    input  logic [D-1:0] Waddr,
    input  logic [W-1:0] DataIn,
    input  logic         LdWriteEn,
    input  logic [D-1:0] LdWaddr,
    input  logic [W-1:0] LdDataIn,
    input  logic         SetBusy,
    input  logic [D-1:0] BusyAddr,
    output logic [W-1:0] DataOutA,
    output logic [W-1:0] DataOutB,
    output logic [W-1:0] DataOutBr,
    output logic         BusyA,
    output logic         BusyB,
    output logic         Stall
);

    localparam int N = 1 << D;

    // Storage and scoreboard state
    logic [W-1:0] regs_q [N];
    logic [W-1:0] regs_d [N];
    logic [N-1:0] busy_q;
    logic [N-1:0] busy_d;

    // Qualified write/busy strobes after stall and R0 filtering
    logic         aluWe;
    logic         ldWe;
    logic         setBusyEff;

    // True when a pointer names the hardwired-zero register
    function automatic logic isZeroReg(input logic [D-1:0] addr);
        return (ZERO_R0 != 0) && (addr == '0);
    endfunction

    // Busy seen by a read port. With bypass, a load returning to that
    // register this cycle already supplies the data, so the read port must
    // not report it as busy.
    function automatic logic readBusy(input logic [D-1:0] addr);
        logic b;
        b = busy_q[addr];
        if ((BYPASS != 0) && LdWriteEn && (LdWaddr == addr)) begin
            b = 1'b0;
        end
        return b;
    endfunction

    // Hazard detection: RAW on either operand, WAW from an ALU write, or a
    // second load issued to a register that is already outstanding.
    always_comb begin
        BusyA = readBusy(RaddrA);
        BusyB = readBusy(RaddrB);
        Stall = BusyA | BusyB
              | (WriteEn & busy_q[Waddr])
              | (SetBusy & busy_q[BusyAddr]);
    end

    // The front end is frozen on Stall, so its ALU write and load issue are
    // dropped. Load returns come from the memory side and always proceed.
    // Writes to a hardwired R0 are discarded here so nothing downstream
    // needs a separate check.
    always_comb begin
        aluWe      = WriteEn & ~Stall & ~isZeroReg(Waddr);
        ldWe       = LdWriteEn & ~isZeroReg(LdWaddr);
        setBusyEff = SetBusy & ~Stall & ~isZeroReg(BusyAddr);
    end

    // Read mux. Port 0 is the younger instruction, so its forwarded data
    // takes priority over a load return to the same register. Reset
    // discards writes, so forwarding is also disabled during reset.
    function automatic logic [W-1:0] readPort(input logic [D-1:0] addr);
        logic [W-1:0] v;
        v = regs_q[addr];
        if ((BYPASS != 0) && !Reset) begin
            if (ldWe && (LdWaddr == addr)) begin
                v = LdDataIn;
            end
            if (aluWe && (Waddr == addr)) begin
                v = DataIn;
            end
        end
        if (isZeroReg(addr)) begin
            v = '0;
        end
        return v;
    endfunction

    // All three read ports use the same forwarding rules
    always_comb begin
        DataOutA  = readPort(RaddrA);
        DataOutB  = readPort(RaddrB);
        DataOutBr = readPort(Waddr);
    end

    // Register next state. The load is applied first and the ALU write
    // second, so the ALU wins when both target the same register.
    always_comb begin
        regs_d = regs_q;
        if (ldWe) begin
            regs_d[LdWaddr] = LdDataIn;
        end
        if (aluWe) begin
            regs_d[Waddr] = DataIn;
        end
    end

    // Scoreboard next state. A load return clears its bit. A newly issued
    // load is applied afterwards, so on a same-cycle conflict the set wins.
    // ALU writes never change the busy bits.
    always_comb begin
        busy_d = busy_q;
        if (LdWriteEn) begin
            busy_d[LdWaddr] = 1'b0;
        end
        if (setBusyEff) begin
            busy_d[BusyAddr] = 1'b1;
        end
        if (ZERO_R0 != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    // State registers. Reset drops outstanding loads. A load that returns
    // after a reset then writes normally and clears a bit that is already
    // clear.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < N; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q <= busy_d;
        end
    end

endmodule
